sklansky_all: RTL and testbench
===============================

SKLANSKY_ALL -- requirements
Module: sklansky_all

Interface
REQ-001 Parameter WIDTH, default 6, operand and sum width in bits; all requirements below hold for WIDTH=6 and for any WIDTH from 2 to 32.
REQ-002 Port clk, input, 1 bit: single clock; the only registered state is sampled on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port a, input, WIDTH bits: first unsigned addend.
REQ-005 Port b, input, WIDTH bits: second unsigned addend.
REQ-006 Port s, output, WIDTH bits: combinational sum bits, (a+b) mod 2^WIDTH.
REQ-007 Port c6, output, 1 bit: combinational carry-out, bit WIDTH of a+b.
REQ-008 Port s_q, output, WIDTH bits: registered copy of s.
REQ-009 Port c6_q, output, 1 bit: registered copy of c6.
REQ-010 The first four ports in positional order after clk and rst_n SHALL be a, b, s, c6.

Function
REQ-011 {c6, s} SHALL equal the (WIDTH+1)-bit unsigned sum a+b for every input combination, with no carry-in.
REQ-012 s and c6 SHALL be purely combinational, with zero cycles of latency, and independent of clk and rst_n.
REQ-013 Bit-level signals: g[i]=a[i]&b[i] and p[i]=a[i]^b[i] for i=0..WIDTH-1.
REQ-014 Carries SHALL be computed by a Sklansky (divide-and-conquer) parallel-prefix tree.
- Number of levels: ceil(log2(WIDTH)); 3 levels for WIDTH=6.
- At level k, each bit in the upper half of every 2^(k+1)-bit block combines with the group signal of the top bit of the lower half of that block.
- Prefix operator: (G,P)o(G',P') = (G | P&G', P&P').
REQ-015 Outputs: s[0]=p[0]; s[i]=p[i]^G[i-1:0] for i>=1; c6=G[WIDTH-1:0].
REQ-016 A ripple-carry chain SHALL NOT be used; the critical path SHALL be ceil(log2(WIDTH)) prefix cells plus one XOR.
REQ-017 On each rising clk edge with rst_n high, s_q<=s and c6_q<=c6, giving one cycle of latency relative to a and b.
REQ-018 The design SHALL contain no X-propagation sources; with known inputs, all outputs are known.
REQ-019 Boundaries:
- 0+0 yields all zeros.
- Max+max yields c6=1 and s=2^WIDTH-2.
- Max+1 wraps to s=0, c6=1.

Reset
REQ-020 While rst_n is low, s_q SHALL be 0 and c6_q SHALL be 0, asynchronously, without waiting for a clk edge.
REQ-021 Reset SHALL NOT affect s or c6; the combinational sum remains valid during reset.
REQ-022 On the first rising clk edge after rst_n deasserts, s_q/c6_q SHALL load the current sum.
REQ-023 If reset is asserted mid-operation, the registered outputs SHALL clear immediately and the in-flight value is discarded.

Verification
REQ-024 Exhaustive check: all 64x64 pairs of a,b with 1 time unit settle each -> {c6,s}==a+b in every case, with a final report of 4096 correct and 0 errors.
REQ-025 Carry chain:
- a=6'b111111, b=6'b000001 -> s=000000, c6=1.
- a=6'b011111, b=6'b000001 -> s=100000, c6=0.
REQ-026 Extremes:
- a=0, b=0 -> s=0, c6=0.
- a=63, b=63 -> s=62 (6'b111110), c6=1.
REQ-027 Registered path: apply a=21, b=42, then one rising clk -> s_q=63, c6_q=0; change to a=40, b=40, then one clk -> s_q=16, c6_q=1.
REQ-028 Async reset: with s_q=63, pull rst_n low between clk edges -> s_q=0 and c6_q=0 immediately while s still shows a+b; release rst_n, then one clk -> s_q reloads the sum.

Source files
------------

// File: rtl/sklansky_all.sv
// rtl/sklansky_all.sv - Sklansky parallel-prefix adder with combinational and registered sum
module sklansky_all #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c6,
    output logic [WIDTH-1:0] s_q,
    output logic             c6_q
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_grp;

    assign g = a & b;
    assign p = a ^ b;

    // Each level holds prefix groups; the group P is only carried forward when a later level needs it.
    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] g_out;

        if (k == 0) begin : src0
            assign g_in = g;
            assign p_in = p;
        end else begin : srcn
            assign g_in = lvl[k-1].g_out;
            assign p_in = lvl[k-1].pp.p_out;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : gbit
            if (((i >> k) % 2) == 1) begin : comb
                localparam int J = ((i >> k) << k) - 1;
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[J]);
            end else begin : pass
                assign g_out[i] = g_in[i];
            end
        end

        if (k < LEVELS - 1) begin : pp
            logic [WIDTH-1:0] p_out;
            for (genvar i = 0; i < WIDTH; i++) begin : pbit
                if (((i >> k) % 2) == 1) begin : comb
                    localparam int J = ((i >> k) << k) - 1;
                    assign p_out[i] = p_in[i] & p_in[J];
                end else begin : pass
                    assign p_out[i] = p_in[i];
                end
            end
        end
    end

    assign g_grp = lvl[LEVELS-1].g_out;

    // g_grp[i] is the carry out of bits i..0, i.e. the carry into bit i+1.
    assign s  = p ^ {g_grp[WIDTH-2:0], 1'b0};
    assign c6 = g_grp[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            c6_q <= 1'b0;
        end else begin
            s_q  <= s;
            c6_q <= c6;
        end
    end

endmodule

// File: tb/tb_sklansky_all.sv
// tb/tb_sklansky_all.sv - self-checking bench for sklansky_all against an arithmetic model
module tb_sklansky_all;

    localparam int W = 6;
    localparam logic [W-1:0] MAXV = '1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] s;
    logic         c6;
    logic [W-1:0] s_q;
    logic         c6_q;

    int n_checks = 0;
    int n_err    = 0;
    int n_ok_ex  = 0;
    int n_err_ex = 0;
    bit cmp_en   = 1'b0;

    logic [W:0] exp_q;

    sklansky_all #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .s    (s),
        .c6   (c6),
        .s_q  (s_q),
        .c6_q (c6_q)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] sum(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Registered outputs must equal the sum seen at the previous rising edge, or zero under reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q = '0;
        else        exp_q = sum(a, b);
    end

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (a=%0d b=%0d)", name, act, exp, a, b);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("comb_sum", {c6, s}, sum(a, b));
            chk("reg_sum", {c6_q, s_q}, exp_q);
        end
    end

    initial begin
        #1;
        chk("reset_s_q", {c6_q, s_q}, '0);

        // Exhaustive combinational sweep while held in reset: sum must stay valid.
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                a = W'(i);
                b = W'(j);
                #1;
                n_checks++;
                if ({c6, s} !== 7'(i + j)) begin
                    n_err++;
                    n_err_ex++;
                    $display("FAIL exhaustive: a=%0d b=%0d got %0d expected %0d", i, j, {c6, s}, i + j);
                end else begin
                    n_ok_ex++;
                end
            end
        end
        $display("exhaustive: %0d correct, %0d errors", n_ok_ex, n_err_ex);

        a = MAXV;     b = 6'd1;  #1; chk("max_plus_1", {c6, s}, {1'b1, 6'b000000});
        a = 6'd31;    b = 6'd1;  #1; chk("carry_to_msb", {c6, s}, {1'b0, 6'b100000});
        a = 6'd0;     b = 6'd0;  #1; chk("zero", {c6, s}, 7'd0);
        a = MAXV;     b = MAXV;  #1; chk("max_plus_max", {c6, s}, {1'b1, 6'b111110});
        chk("reset_hold_s_q", {c6_q, s_q}, '0);

        @(negedge clk);
        a = 6'd21; b = 6'd42; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reg_21_42", {c6_q, s_q}, {1'b0, 6'd63});
        a = 6'd40; b = 6'd40;
        @(posedge clk); #1;
        chk("reg_40_40", {c6_q, s_q}, {1'b1, 6'd16});

        a = 6'd21; b = 6'd42;
        @(posedge clk); #1;
        chk("reg_before_async", {c6_q, s_q}, {1'b0, 6'd63});
        #2 rst_n = 1'b0;
        #1;
        chk("async_clear", {c6_q, s_q}, '0);
        chk("comb_in_reset", {c6, s}, {1'b0, 6'd63});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reload_after_reset", {c6_q, s_q}, {1'b0, 6'd63});

        cmp_en = 1'b1;
        repeat (500) begin
            @(posedge clk);
            #2;
            a = ($urandom_range(0, 7) == 0) ? MAXV : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? MAXV : W'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                chk("midrun_async_clear", {c6_q, s_q}, '0);
                rst_n = 1'b1;
            end
        end
        @(posedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
